sta_path_engine: RTL and testbench

//  Parametrised critical-path engine for gate-level DAG timing. It loads node delays and

---
 rtl/sta_path_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_sta_path_engine.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sta_path_engine.sv
// Critical-path engine: loads a node-delay table and an edge list, runs a Kahn-ordered
// longest-path pass from start_node, then streams the worst delay and the path start..end.
module sta_path_engine #(
  parameter int NUM_NODE = 16,
  parameter int NUM_EDGE = 32,
  parameter int DW       = 4,
  parameter int WW       = 8,
  localparam int IW      = $clog2(NUM_NODE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] delay,
  input  logic [IW-1:0] source,
  input  logic [IW-1:0] destination,
  input  logic [IW-1:0] start_node,
  input  logic [IW-1:0] end_node,
  output logic          out_valid,
  output logic [WW-1:0] worst_delay,
  output logic [IW-1:0] path,
  output logic [1:0]    err
);

  localparam int CW = $clog2(NUM_NODE + 1);
  localparam int LW = $clog2(NUM_EDGE);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACCU, S_TRACE, S_OUT} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       start_q, start_d, end_q, end_d;
  logic [IW-1:0]       cur_q, cur_d, sp_q, sp_d;
  logic [NUM_NODE-1:0] adj_q [NUM_NODE];
  logic [NUM_NODE-1:0] adj_d [NUM_NODE];
  logic [CW-1:0]       indeg_q [NUM_NODE];
  logic [CW-1:0]       indeg_d [NUM_NODE];
  logic [DW-1:0]       delay_q [NUM_NODE];
  logic [DW-1:0]       delay_d [NUM_NODE];
  logic [WW-1:0]       acc_q [NUM_NODE];
  logic [WW-1:0]       acc_d [NUM_NODE];
  logic [IW-1:0]       pred_q [NUM_NODE];
  logic [IW-1:0]       pred_d [NUM_NODE];
  logic [IW-1:0]       stk_q [NUM_NODE];
  logic [IW-1:0]       stk_d [NUM_NODE];
  logic [NUM_NODE-1:0] reached_q, reached_d, pending_q, pending_d;
  logic                out_valid_q, out_valid_d;
  logic [WW-1:0]       worst_q, worst_d;
  logic [IW-1:0]       path_q, path_d;
  logic [1:0]          err_q, err_d;

  logic                found;
  logic [IW-1:0]       cand;
  logic [WW-1:0]       sum;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_d     = start_q;
    end_d       = end_q;
    cur_d       = cur_q;
    sp_d        = sp_q;
    adj_d       = adj_q;
    indeg_d     = indeg_q;
    delay_d     = delay_q;
    acc_d       = acc_q;
    pred_d      = pred_q;
    stk_d       = stk_q;
    reached_d   = reached_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    worst_d     = worst_q;
    path_d      = path_q;
    err_d       = err_q;
    found       = 1'b0;
    cand        = '0;
    sum         = '0;

    // Burst capture; duplicate edges leave indegree untouched.
    if (in_valid && (state_q == S_IDLE || state_q == S_LOAD)) begin
      if (int'(cnt_q) < NUM_NODE) delay_d[IW'(cnt_q)] = delay;
      if (!adj_q[source][destination]) begin
        adj_d[source][destination] = 1'b1;
        indeg_d[destination]       = indeg_q[destination] + 1'b1;
      end
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          start_d = start_node;
          end_d   = end_node;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid && cnt_q == LW'(NUM_EDGE - 1)) begin
          cnt_d              = '0;
          pending_d          = '1;
          acc_d[start_q]     = WW'(delay_d[start_q]);
          reached_d[start_q] = 1'b1;
          state_d            = S_ACCU;
        end
      end
      S_ACCU: begin
        for (int i = NUM_NODE - 1; i >= 0; i--) begin
          if (pending_q[i] && indeg_q[i] == '0) begin
            found = 1'b1;
            cand  = IW'(i);
          end
        end
        if (found) begin
          pending_d[cand] = 1'b0;
          for (int j = 0; j < NUM_NODE; j++) begin
            if (adj_q[cand][j]) begin
              indeg_d[j] = indeg_q[j] - 1'b1;
              sum        = acc_q[cand] + WW'(delay_q[j]);
              // Strict compare: on a tie the earlier-processed predecessor stays.
              if (reached_q[cand] && sum > acc_q[j]) begin
                acc_d[j]     = sum;
                pred_d[j]    = cand;
                reached_d[j] = 1'b1;
              end
            end
          end
        end else if (|pending_q || !reached_q[end_q]) begin
          out_valid_d = 1'b1;
          worst_d     = '0;
          path_d      = '0;
          err_d       = (|pending_q) ? 2'd1 : 2'd2;
          sp_d        = '0;
          state_d     = S_OUT;
        end else begin
          cur_d   = end_q;
          sp_d    = '0;
          state_d = S_TRACE;
        end
      end
      S_TRACE: begin
        // The stack holds end..second node; start is emitted directly on entry to OUT.
        if (cur_q == start_q) begin
          out_valid_d = 1'b1;
          path_d      = cur_q;
          worst_d     = acc_q[end_q];
          err_d       = 2'd0;
          state_d     = S_OUT;
        end else begin
          stk_d[sp_q] = cur_q;
          sp_d        = sp_q + 1'b1;
          cur_d       = pred_q[cur_q];
        end
      end
      S_OUT: begin
        if (sp_q == '0) begin
          out_valid_d = 1'b0;
          worst_d     = '0;
          path_d      = '0;
          err_d       = 2'd0;
          cnt_d       = '0;
          reached_d   = '0;
          pending_d   = '0;
          for (int i = 0; i < NUM_NODE; i++) begin
            adj_d[i]   = '0;
            indeg_d[i] = '0;
            delay_d[i] = '0;
            acc_d[i]   = '0;
            pred_d[i]  = '0;
          end
          state_d = S_IDLE;
        end else begin
          sp_d    = sp_q - 1'b1;
          path_d  = stk_q[sp_d];
          worst_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      start_q     <= '0;
      end_q       <= '0;
      cur_q       <= '0;
      sp_q        <= '0;
      reached_q   <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      worst_q     <= '0;
      path_q      <= '0;
      err_q       <= 2'd0;
      for (int i = 0; i < NUM_NODE; i++) begin
        adj_q[i]   <= '0;
        indeg_q[i] <= '0;
        delay_q[i] <= '0;
        acc_q[i]   <= '0;
        pred_q[i]  <= '0;
        stk_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      end_q       <= end_d;
      cur_q       <= cur_d;
      sp_q        <= sp_d;
      reached_q   <= reached_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      worst_q     <= worst_d;
      path_q      <= path_d;
      err_q       <= err_d;
      for (int i = 0; i < NUM_NODE; i++) begin
        adj_q[i]   <= adj_d[i];
        indeg_q[i] <= indeg_d[i];
        delay_q[i] <= delay_d[i];
        acc_q[i]   <= acc_d[i];
        pred_q[i]  <= pred_d[i];
        stk_q[i]   <= stk_d[i];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign worst_delay = worst_q;
  assign path        = path_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sta_path_engine.sv
// Bench for sta_path_engine: directed and random graphs on a default and a wide instance,
// checked against a topological-order longest-path model.
module tb_sta_path_engine;

  localparam int N0 = 16, E0 = 32, D0 = 4, W0 = 8,  I0 = 4;
  localparam int N1 = 32, E1 = 64, D1 = 8, W1 = 13, I1 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          iv0 = 1'b0, ov0;
  logic [D0-1:0] dl0 = '0;
  logic [I0-1:0] src0 = '0, dst0 = '0, st0 = '0, en0 = '0, p0;
  logic [W0-1:0] wd0;
  logic [1:0]    er0;

  logic          iv1 = 1'b0, ov1;
  logic [D1-1:0] dl1 = '0;
  logic [I1-1:0] src1 = '0, dst1 = '0, st1 = '0, en1 = '0, p1;
  logic [W1-1:0] wd1;
  logic [1:0]    er1;

  sta_path_engine #(.NUM_NODE(N0), .NUM_EDGE(E0), .DW(D0), .WW(W0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .delay(dl0), .source(src0),
    .destination(dst0), .start_node(st0), .end_node(en0), .out_valid(ov0),
    .worst_delay(wd0), .path(p0), .err(er0));

  sta_path_engine #(.NUM_NODE(N1), .NUM_EDGE(E1), .DW(D1), .WW(W1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .delay(dl1), .source(src1),
    .destination(dst1), .start_node(st1), .end_node(en1), .out_valid(ov1),
    .worst_delay(wd1), .path(p1), .err(er1));

  int n_cmp = 0;
  int n_bad = 0;

  int sel, nn, ne;
  int g_delay[64];
  int g_src[64];
  int g_dst[64];
  int g_start, g_end;

  int exp_err, exp_worst;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Longest path over a lowest-index-first topological order.
  function automatic void model();
    bit adj[32][32];
    int indeg[32];
    int acc[32];
    int pred[32];
    bit reached[32];
    bit done[32];
    int order[$];
    int pick, n, cur;
    for (int i = 0; i < 32; i++) begin
      indeg[i] = 0; acc[i] = 0; pred[i] = 0; reached[i] = 0; done[i] = 0;
      for (int j = 0; j < 32; j++) adj[i][j] = 0;
    end
    for (int e = 0; e < ne; e++) begin
      if (!adj[g_src[e]][g_dst[e]]) begin
        adj[g_src[e]][g_dst[e]] = 1;
        indeg[g_dst[e]]++;
      end
    end
    forever begin
      pick = -1;
      for (int i = nn - 1; i >= 0; i--) if (!done[i] && indeg[i] == 0) pick = i;
      if (pick < 0) break;
      done[pick] = 1;
      order.push_back(pick);
      for (int j = 0; j < nn; j++) if (adj[pick][j]) indeg[j]--;
    end
    acc[g_start] = g_delay[g_start];
    reached[g_start] = 1;
    foreach (order[k]) begin
      n = order[k];
      if (reached[n]) begin
        for (int j = 0; j < nn; j++) begin
          if (adj[n][j] && acc[n] + g_delay[j] > acc[j]) begin
            acc[j] = acc[n] + g_delay[j];
            pred[j] = n;
            reached[j] = 1;
          end
        end
      end
    end
    exp_q.delete();
    if (order.size() < nn || !reached[g_end]) begin
      exp_err = (order.size() < nn) ? 1 : 2;
      exp_worst = 0;
      exp_q.push_back(16'd0);
    end else begin
      exp_err = 0;
      exp_worst = acc[g_end];
      cur = g_end;
      while (cur != g_start) begin
        exp_q.push_front(16'(cur));
        cur = pred[cur];
      end
      exp_q.push_front(16'(g_start));
    end
  endfunction

  task automatic sample(output logic ov, output logic [31:0] wd, output logic [31:0] p,
                        output logic [31:0] er);
    if (sel == 0) begin
      ov = ov0; wd = 32'(wd0); p = 32'(p0); er = 32'(er0);
    end else begin
      ov = ov1; wd = 32'(wd1); p = 32'(p1); er = 32'(er1);
    end
  endtask

  task automatic drive_burst();
    for (int e = 0; e < ne; e++) begin
      @(negedge clk);
      if (sel == 0) begin
        iv0  = 1'b1;
        dl0  = (e < nn) ? D0'(g_delay[e]) : D0'($urandom);
        src0 = I0'(g_src[e]);
        dst0 = I0'(g_dst[e]);
        st0  = (e == 0) ? I0'(g_start) : I0'($urandom);
        en0  = (e == 0) ? I0'(g_end) : I0'($urandom);
      end else begin
        iv1  = 1'b1;
        dl1  = (e < nn) ? D1'(g_delay[e]) : D1'($urandom);
        src1 = I1'(g_src[e]);
        dst1 = I1'(g_dst[e]);
        st1  = (e == 0) ? I1'(g_start) : I1'($urandom);
        en1  = (e == 0) ? I1'(g_end) : I1'($urandom);
      end
    end
    @(negedge clk);
    iv0 = 1'b0;
    iv1 = 1'b0;
  endtask

  // want_worst >= 0 adds a check against a hand-derived value.
  task automatic collect(input string name, input int want_worst);
    logic ov;
    logic [31:0] wd, p, er;
    int waited, k, exp_len;
    logic [15:0] exp_p;
    model();
    exp_len = exp_q.size();
    waited = 0;
    sample(ov, wd, p, er);
    while (!ov && waited < 2 * nn + 2) begin
      check({name, "_idle_zero"}, 32'((wd != 0) || (p != 0) || (er != 0)), 32'd0);
      @(negedge clk);
      waited++;
      sample(ov, wd, p, er);
    end
    check({name, "_latency"}, 32'(ov), 32'd1);
    if (!ov) return;
    check({name, "_worst"}, wd, 32'(exp_worst));
    if (want_worst >= 0) check({name, "_worst_spec"}, wd, 32'(want_worst));
    k = 0;
    while (ov && k < 40) begin
      exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
      check({name, "_path"}, p, 32'(exp_p));
      check({name, "_err"}, er, 32'(exp_err));
      if (k > 0) check({name, "_worst_tail"}, wd, 32'd0);
      k++;
      @(negedge clk);
      sample(ov, wd, p, er);
    end
    check({name, "_len"}, 32'(k), 32'(exp_len));
  endtask

  task automatic fill_edges(input int s, input int d);
    for (int e = 0; e < ne; e++) begin
      g_src[e] = s;
      g_dst[e] = d;
    end
  endtask

  task automatic set_delays(input int v);
    for (int i = 0; i < nn; i++) g_delay[i] = v;
  endtask

  task automatic setup_chain_test();
    set_delays(1);
    fill_edges(0, 4);
    g_src[0] = 0; g_dst[0] = 2;
    g_src[1] = 2; g_dst[1] = 3;
    g_src[2] = 3; g_dst[2] = 1;
    g_start = 0; g_end = 1;
  endtask

  task automatic gen_random(input int mode);
    int a, b, dmax;
    dmax = (sel == 0) ? 15 : 255;
    for (int i = 0; i < nn; i++) g_delay[i] = $urandom_range(dmax, 1);
    for (int e = 0; e < ne; e++) begin
      if (mode == 0) begin
        a = $urandom_range(nn - 2, 0);
        b = a + 1 + $urandom_range(2, 0);
        if (b > nn - 1) b = nn - 1;
      end else begin
        a = $urandom_range(nn - 1, 0);
        b = $urandom_range(nn - 1, 0);
      end
      g_src[e] = a;
      g_dst[e] = b;
    end
    g_start = $urandom_range(3, 0);
    g_end   = $urandom_range(nn - 1, 0);
  endtask

  initial begin : main
    int seen;
    logic ov;
    logic [31:0] wd, p, er;

    sel = 0; nn = N0; ne = E0;
    repeat (3) @(negedge clk);
    check("reset_ov0", 32'(ov0), 32'd0);
    check("reset_outs0", 32'(wd0) | 32'(p0) | 32'(er0), 32'd0);
    check("reset_ov1", 32'(ov1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    setup_chain_test();
    drive_burst();
    collect("t1_chain", 4);

    set_delays(3);
    g_delay[0] = 1; g_delay[1] = 1; g_delay[2] = 5; g_delay[3] = 5;
    fill_edges(0, 2);
    g_src[1] = 2; g_dst[1] = 1;
    g_src[2] = 0; g_dst[2] = 3;
    g_src[3] = 3; g_dst[3] = 1;
    g_start = 0; g_end = 1;
    drive_burst();
    collect("t2_diamond", 7);

    set_delays(2);
    fill_edges(0, 1);
    g_src[0] = 2; g_dst[0] = 3;
    g_src[1] = 3; g_dst[1] = 2;
    g_start = 0; g_end = 1;
    drive_burst();
    collect("t3_cycle", 0);

    set_delays(4);
    fill_edges(9, 5);
    g_src[0] = 5; g_dst[0] = 6;
    g_src[1] = 6; g_dst[1] = 7;
    g_start = 5; g_end = 9;
    drive_burst();
    collect("t4_unreach", 0);

    set_delays(1);
    g_delay[7] = 15;
    fill_edges(0, 1);
    g_start = 7; g_end = 7;
    drive_burst();
    collect("t5_same", 15);

    setup_chain_test();
    drive_burst();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_ov", 32'(ov0), 32'd0);
    check("t6_rst_outs", 32'(wd0) | 32'(p0) | 32'(er0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      sample(ov, wd, p, er);
      if (ov || wd != 0 || p != 0 || er != 0) seen++;
    end
    check("t6_no_partial", 32'(seen), 32'd0);
    drive_burst();
    collect("t6_after_rst", 4);

    for (int r = 0; r < 40; r++) begin
      gen_random(r % 3 == 2 ? 1 : 0);
      drive_burst();
      collect("rand16", -1);
    end

    sel = 1; nn = N1; ne = E1;
    set_delays(255);
    fill_edges(0, 1);
    for (int i = 0; i < 31; i++) begin
      g_src[i] = i;
      g_dst[i] = i + 1;
    end
    g_start = 0; g_end = 31;
    drive_burst();
    collect("t6_wide_chain", 8160);

    for (int r = 0; r < 8; r++) begin
      gen_random(r % 4 == 3 ? 1 : 0);
      drive_burst();
      collect("rand32", -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
